serial_add_ctrl: RTL

//   Bit-serial adder sequencer. It time-multiplexes one full-adder cell across WIDTH operand bits, one bit per clock.

---
 rtl/serial_add_pkg.sv | 19 +
 rtl/fa_bit.sv | 15 +
 rtl/serial_add_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg -- shared types and constants for the bit-serial adder.
//   state_t        : sequencer states (IDLE -> RUN -> FIN -> IDLE)
//   WIDTH_DEFAULT  : default operand width
//   cnt_w()        : bit-step counter width for a given operand width
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 4;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/fa_bit.sv
// fa_bit -- single combinational full-adder cell, shared by every bit step.
//   a, b, cin : operand bits and carry-in
//   s, cout   : sum bit and carry-out
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl -- bit-serial adder sequencer. One full-adder cell is
// reused across WIDTH operand bits, LSB first, one bit per clock.
// Optional feature macro: SERIAL_ADD_OVF_EN (adds the signed-overflow port ovf).
//   clk   : system clock, all state on rising edge
//   rst   : synchronous active-high reset
//   start : request, sampled only in IDLE
//   a, b  : operands, captured on accepted start
//   cin   : carry-in, captured on accepted start
//   busy  : high while bit-steps are running
//   done  : one-cycle pulse, sum/cout valid
//   sum   : result, held from done until next accepted start
//   cout  : final carry-out, held with sum
//   ovf   : signed overflow, held with sum (SERIAL_ADD_OVF_EN only)
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_sr_reg, b_sr_reg, sum_reg;
  logic             carry_reg, cout_reg;
  logic             fa_s, fa_cout;
  logic             last_step;

  fa_bit u_fa (
    .a    (a_sr_reg[0]),
    .b    (b_sr_reg[0]),
    .cin  (carry_reg),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_step = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last_step) state_next = ST_FIN;
      end
      ST_FIN: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: operands shift right so bit 0 always feeds the adder cell;
  // each new sum bit enters at the MSB so after WIDTH steps bit 0 is at LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      a_sr_reg  <= '0;
      b_sr_reg  <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: if (start) begin
          a_sr_reg  <= a;
          b_sr_reg  <= b;
          carry_reg <= cin;
          cnt_reg   <= '0;
          sum_reg   <= '0;
          cout_reg  <= 1'b0;
        end
        ST_RUN: begin
          a_sr_reg  <= a_sr_reg >> 1;
          b_sr_reg  <= b_sr_reg >> 1;
          sum_reg   <= {fa_s, sum_reg[WIDTH-1:1]};
          carry_reg <= fa_cout;
          // Return to zero rather than count past WIDTH-1.
          cnt_reg   <= last_step ? '0 : cnt_reg + CW'(1);
          if (last_step) cout_reg <= fa_cout;
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_reg;

  // On the last step carry_reg is the carry into the MSB.
  always_ff @(posedge clk) begin
    if (rst)                                 ovf_reg <= 1'b0;
    else if (state_reg == ST_IDLE && start)  ovf_reg <= 1'b0;
    else if (state_reg == ST_RUN && last_step) ovf_reg <= carry_reg ^ fa_cout;
  end

  assign ovf = ovf_reg;
`endif

endmodule
